// File: rtl/led_scan_scheduler.sv
// Time-multiplexed 4-digit scan controller sharing one external hex-to-7-seg decoder.
// Optional inter-digit blanking is compiled in with `define LED_SCAN_BLANK_EN.
`timescale 1ns/1ps
module led_scan_scheduler #(
  parameter int unsigned DIGIT_CYCLES = 16,
  parameter int unsigned BLANK_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [15:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [3:0]  char,
  input  logic [6:0]  seg_in,
  output logic [6:0]  seg_out,
  output logic [3:0]  an,
  output logic        frame_tick
);

  localparam int unsigned CNT_MAX = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] DIGIT_LAST = CNT_W'(DIGIT_CYCLES - 1);
`ifdef LED_SCAN_BLANK_EN
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
`endif

  typedef enum logic [0:0] {ST_BLANK = 1'b0, ST_SHOW = 1'b1} state_e;

`ifdef LED_SCAN_BLANK_EN
  localparam state_e ST_RESET = ST_BLANK;
  localparam state_e ST_AFTER = ST_BLANK;
`else
  localparam state_e ST_RESET = ST_SHOW;
  localparam state_e ST_AFTER = ST_SHOW;
`endif

  state_e           state_q, state_d;
  logic [1:0]       digit_q, digit_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      disp_q, disp_d;
  logic [15:0]      shadow_q, shadow_d;
  logic             pending_q, pending_d;
  logic [6:0]       seg_q, seg_d;
  logic [3:0]       an_q, an_d;
  logic             tick_q;
  logic             boundary_c;
  logic             accept_c;
  logic             lit_c;

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_RESET;
      digit_q   <= 2'd0;
      cnt_q     <= '0;
      disp_q    <= 16'h0000;
      shadow_q  <= 16'h0000;
      pending_q <= 1'b0;
      seg_q     <= 7'h7F;
      an_q      <= 4'hF;
      tick_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      digit_q   <= digit_d;
      cnt_q     <= cnt_d;
      disp_q    <= disp_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      seg_q     <= seg_d;
      an_q      <= an_d;
      tick_q    <= boundary_c;
    end
  end

  // Scan sequencing, frame commit and handshake
  always_comb begin
    state_d    = state_q;
    digit_d    = digit_q;
    cnt_d      = cnt_q + CNT_W'(1);
    boundary_c = 1'b0;
    disp_d     = disp_q;
    shadow_d   = shadow_q;
    pending_d  = pending_q;
    accept_c   = in_valid && !pending_q;

    case (state_q)
`ifdef LED_SCAN_BLANK_EN
      ST_BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          state_d = ST_SHOW;
          cnt_d   = '0;
        end
      end
`endif
      ST_SHOW: begin
        if (cnt_q == DIGIT_LAST) begin
          cnt_d      = '0;
          digit_d    = digit_q + 2'd1;
          state_d    = ST_AFTER;
          boundary_c = (digit_q == 2'd3);
        end
      end
      default: begin
        state_d = ST_RESET;
        cnt_d   = '0;
      end
    endcase

    // Commit sees the pre-accept shadow, so a same-edge accept waits a frame
    if (boundary_c && pending_q) begin
      disp_d    = shadow_q;
      pending_d = 1'b0;
    end
    if (accept_c) begin
      shadow_d  = in_data;
      pending_d = 1'b1;
    end

    lit_c = (state_q == ST_SHOW) && enable;
    seg_d = lit_c ? seg_in : 7'h7F;
    an_d  = lit_c ? ~(4'b0001 << digit_q) : 4'hF;
  end

  assign char       = disp_q[{digit_q, 2'b00} +: 4];
  assign in_ready   = ~pending_q;
  assign seg_out    = seg_q;
  assign an         = an_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_led_scan_scheduler.sv
// Directed self-checking bench for led_scan_scheduler; adapts to LED_SCAN_BLANK_EN.
`timescale 1ns/1ps
module tb_led_scan_scheduler;

  localparam int D = 16;
`ifdef LED_SCAN_BLANK_EN
  localparam int B = 2;
`else
  localparam int B = 0;
`endif
  localparam int SLOT  = D + B;
  localparam int FRAME = 4 * SLOT;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  char_w;
  logic [6:0]  seg_in;
  logic [6:0]  seg_out;
  logic [3:0]  an;
  logic        frame_tick;

  int n_vec;
  int n_err;
  int phase;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: return 7'h40; 4'h1: return 7'h79; 4'h2: return 7'h24; 4'h3: return 7'h30;
      4'h4: return 7'h19; 4'h5: return 7'h12; 4'h6: return 7'h02; 4'h7: return 7'h78;
      4'h8: return 7'h00; 4'h9: return 7'h10; 4'hA: return 7'h08; 4'hB: return 7'h03;
      4'hC: return 7'h46; 4'hD: return 7'h21; 4'hE: return 7'h06; default: return 7'h0E;
    endcase
  endfunction

  assign seg_in = hex7(char_w);

  led_scan_scheduler #(.DIGIT_CYCLES(D), .BLANK_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .char(char_w), .seg_in(seg_in), .seg_out(seg_out), .an(an),
    .frame_tick(frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // phase = edges since the last frame boundary (0 right after the tick edge)
  task automatic step();
    logic r;
    r = reset;
    @(posedge clk);
    #1;
    phase = r ? 0 : (phase + 1) % FRAME;
  endtask

  function automatic logic [3:0] exp_an(input int p, input logic en);
    int q, slot, off;
    logic [3:0] one;
    one  = 4'b0001;
    q    = (p + FRAME - 1) % FRAME;
    slot = q / SLOT;
    off  = q % SLOT;
    if (en && off >= B) return ~(one << slot);
    return 4'hF;
  endfunction

  function automatic logic [6:0] exp_seg(input int p, input logic en, input logic [15:0] word);
    int q, slot, off;
    logic [15:0] w;
    w    = word;
    q    = (p + FRAME - 1) % FRAME;
    slot = q / SLOT;
    off  = q % SLOT;
    if (en && off >= B) return hex7(w[slot*4 +: 4]);
    return 7'h7F;
  endfunction

  task automatic run_check(input logic [15:0] word, input int n, input string tag);
    logic [3:0] ea;
    logic [6:0] es;
    logic       et;
    logic       en;
    for (int i = 0; i < n; i++) begin
      en = enable;
      step();
      ea = exp_an(phase, en);
      es = exp_seg(phase, en, word);
      et = (phase == 0);
      n_vec++;
      if (an !== ea || seg_out !== es || frame_tick !== et) begin
        n_err++;
        $display("FAIL %s phase %0d: an=%b seg=%h tick=%b, expected an=%b seg=%h tick=%b",
                 tag, phase, an, seg_out, frame_tick, ea, es, et);
      end
    end
  endtask

  task automatic run_to_phase(input logic [15:0] word, input int target, input string tag);
    run_check(word, (target - phase + FRAME) % FRAME, tag);
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; in_valid = 1'b0; in_data = 16'h0000;
    repeat (5) step();
    n_vec++;
    if (an !== 4'hF || seg_out !== 7'h7F || frame_tick !== 1'b0) begin
      n_err++;
      $display("FAIL reset_outputs: an=%b seg=%h tick=%b, expected 1111/7f/0", an, seg_out, frame_tick);
    end
    n_vec++;
    if (in_ready !== 1'b1 || char_w !== 4'h0) begin
      n_err++;
      $display("FAIL reset_ready_char: ready=%b char=%h, expected 1/0", in_ready, char_w);
    end
    reset = 1'b0;
    run_check(16'h0000, FRAME, "first_frame");
  endtask

  task automatic test_word_commit();
    run_to_phase(16'h0000, 20, "commit_pre");
    in_data = 16'h3A5C; in_valid = 1'b1;
    run_check(16'h0000, 1, "commit_accept");
    in_valid = 1'b0;
    n_vec++;
    if (in_ready !== 1'b0) begin
      n_err++; $display("FAIL commit_ready_drop: ready=%b, expected 0", in_ready);
    end
    run_to_phase(16'h0000, FRAME - 1, "commit_old_frame");
    n_vec++;
    if (in_ready !== 1'b0) begin
      n_err++; $display("FAIL commit_ready_hold: ready=%b, expected 0", in_ready);
    end
    run_check(16'h0000, 1, "commit_boundary");
    n_vec++;
    if (in_ready !== 1'b1 || char_w !== 4'hC) begin
      n_err++; $display("FAIL commit_after: ready=%b char=%h, expected 1/c", in_ready, char_w);
    end
    run_check(16'h3A5C, 3 * SLOT, "commit_new_d012");
    n_vec++;
    if (char_w !== 4'h3) begin
      n_err++; $display("FAIL commit_digit3_char: char=%h, expected 3", char_w);
    end
    run_check(16'h3A5C, SLOT, "commit_new_d3");
  endtask

  task automatic test_back_to_back();
    run_check(16'h3A5C, 10, "bp_pre");
    in_data = 16'h1111; in_valid = 1'b1;
    run_check(16'h3A5C, 1, "bp_accept1");
    n_vec++;
    if (in_ready !== 1'b0) begin
      n_err++; $display("FAIL bp_ready_drop: ready=%b, expected 0", in_ready);
    end
    in_data = 16'h2222;
    run_to_phase(16'h3A5C, 0, "bp_frame_n");
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++; $display("FAIL bp_ready_rise: ready=%b, expected 1", in_ready);
    end
    run_check(16'h1111, 1, "bp_accept2");
    in_valid = 1'b0;
    n_vec++;
    if (in_ready !== 1'b0) begin
      n_err++; $display("FAIL bp_ready_drop2: ready=%b, expected 0", in_ready);
    end
    run_check(16'h1111, FRAME - 1, "bp_frame_n1");
    run_check(16'h2222, FRAME, "bp_frame_n2");
  endtask

  task automatic test_simultaneous();
    run_check(16'h2222, FRAME - 1, "sim_pre");
    in_data = 16'hBEEF; in_valid = 1'b1;
    run_check(16'h2222, 1, "sim_boundary");
    in_valid = 1'b0;
    n_vec++;
    if (in_ready !== 1'b0 || char_w !== 4'h2) begin
      n_err++; $display("FAIL sim_hold: ready=%b char=%h, expected 0/2", in_ready, char_w);
    end
    run_check(16'h2222, FRAME, "sim_unchanged");
    n_vec++;
    if (in_ready !== 1'b1 || char_w !== 4'hF) begin
      n_err++; $display("FAIL sim_commit: ready=%b char=%h, expected 1/f", in_ready, char_w);
    end
    run_check(16'hBEEF, FRAME, "sim_beef");
  endtask

  task automatic test_enable();
    run_check(16'hBEEF, 25, "en_pre");
    enable = 1'b0;
    run_check(16'hBEEF, 30, "en_dark");
    enable = 1'b1;
    run_to_phase(16'hBEEF, 0, "en_resume");
    run_check(16'hBEEF, FRAME, "en_next");
  endtask

  task automatic test_reset_mid();
    in_data = 16'h7777; in_valid = 1'b1;
    run_check(16'hBEEF, 1, "rm_accept");
    in_valid = 1'b0;
    n_vec++;
    if (in_ready !== 1'b0) begin
      n_err++; $display("FAIL rm_pending: ready=%b, expected 0", in_ready);
    end
    run_to_phase(16'hBEEF, 2 * SLOT + B + 5, "rm_to_digit2");
    reset = 1'b1;
    step();
    n_vec++;
    if (an !== 4'hF || seg_out !== 7'h7F || frame_tick !== 1'b0) begin
      n_err++;
      $display("FAIL rm_dark: an=%b seg=%h tick=%b, expected 1111/7f/0", an, seg_out, frame_tick);
    end
    n_vec++;
    if (in_ready !== 1'b1 || char_w !== 4'h0) begin
      n_err++; $display("FAIL rm_state: ready=%b char=%h, expected 1/0", in_ready, char_w);
    end
    reset = 1'b0;
    run_check(16'h0000, FRAME, "rm_frame1");
    run_check(16'h0000, FRAME, "rm_frame2");
  endtask

  initial begin
    n_vec = 0; n_err = 0; phase = 0;
    reset = 1'b1; enable = 1'b1; in_valid = 1'b0; in_data = 16'h0000;
    test_reset();
    test_word_commit();
    test_back_to_back();
    test_simultaneous();
    test_enable();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
